// File: rtl/fetch_queue_if.sv
// Fetch stage bus: instruction-memory request/response, core redirect and
// the instruction handshake toward the core.
//   master: the fetch_queue side (drives imem_req/imem_addr and ir/ir_pc/ir_valid)
//   slave : the environment side (memory + core)
interface fetch_queue_if #(
    parameter int unsigned AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rdy;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid,
        input  imem_rdy, imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid,
        output imem_rdy, imem_rvalid, imem_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches under a credit limit,
// buffers returned words with their PCs in a DEPTH-entry prefetch FIFO and
// hands them to the core over a valid/ready handshake. A redirect empties the
// FIFO, restarts fetch at the new target and drops the stale in-flight words.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   bus        - fetch_queue_if.master: imem_req/addr/rdy/rvalid/rdata,
//                redirect/redirect_pc, ir/ir_pc/ir_valid/ir_ready
//
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// ir/ir_pc/ir_valid when the FIFO is empty in RUN (zero-cycle latency).
// Without it every core-facing output comes from registers.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic            req_q, req_d;
    logic [31:0]     ir_q, ir_d;
    logic [AW-1:0]   ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;

    logic [31:0]     data_mem_q [DEPTH];
    logic [AW-1:0]   pc_mem_q   [DEPTH];
    logic [AW-1:0]   tag_mem_q  [DEPTH];

    logic            xfer;
    logic            resp;
    logic [AW-1:0]   resp_pc;
    logic            push;
    logic            fifo_pop;
    logic            byp_take;
    logic [CW:0]     credit_sum;

    assign xfer    = req_q && bus.imem_rdy;
    assign resp    = bus.imem_rvalid;
    // Responses come back in request order, so the tag FIFO head is the PC
    // of whatever word is returning now (stale or not).
    assign resp_pc = tag_mem_q[tag_rd_q];

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp          = (state_q == RUN) && (count_q == '0) && resp;
    assign byp_take     = byp && bus.ir_ready;
    assign bus.ir_valid = byp || ir_valid_q;
    assign bus.ir       = byp ? bus.imem_rdata : ir_q;
    assign bus.ir_pc    = byp ? resp_pc : ir_pc_q;
`else
    assign byp_take     = 1'b0;
    assign bus.ir_valid = ir_valid_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
`endif

    // ir_valid_q mirrors count_q != 0, so this is a pop of the FIFO head only.
    assign fifo_pop = ir_valid_q && bus.ir_ready && !bus.redirect;
    assign push     = resp && (state_q == RUN) && !bus.redirect && !byp_take;

    // Next-state, counters, pointers and output registers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        outst_d    = outst_q + CW'(xfer) - CW'(resp);
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q + PW'(resp);
        tag_wr_d   = tag_wr_q + PW'(xfer);
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = 1'b0;
        req_d      = 1'b0;
        credit_sum = '0;

        if (xfer) begin
            fetch_pc_d = fetch_pc_q + AW'(1);
        end

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            count_d  = count_q + CW'(push) - CW'(fifo_pop);
            rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end

        case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    // Everything still in flight (including this cycle's
                    // transfer) is stale.
                    drop_d  = outst_d;
                    state_d = (outst_d != '0) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                // A redirect here only retargets fetch_pc; the drop count
                // keeps tracking the responses already owed.
                drop_d  = drop_q - CW'(resp);
                state_d = (drop_d == '0) ? RUN : FLUSH;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        credit_sum = {1'b0, count_d} + {1'b0, outst_d};
        req_d      = (state_d == RUN) && (credit_sum < (CW + 1)'(DEPTH));

        // Registered FIFO head; the word written this cycle becomes the head
        // when it lands in the slot rd_ptr_d points at.
        ir_valid_d = (count_d != '0);
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                ir_d    = bus.imem_rdata;
                ir_pc_d = resp_pc;
            end else begin
                ir_d    = data_mem_q[rd_ptr_d];
                ir_pc_d = pc_mem_q[rd_ptr_d];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            req_q      <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            req_q      <= req_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Prefetch data/PC storage and the in-flight PC tag FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
                tag_mem_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                data_mem_q[wr_ptr_q] <= bus.imem_rdata;
                pc_mem_q[wr_ptr_q]   <= resp_pc;
            end
            if (xfer) begin
                tag_mem_q[tag_wr_q] <= fetch_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4, AW=32) with an
// in-order instruction memory model of programmable latency returning
// data = addr + 0x1000.
module tb_fetch_queue;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 1;
    int   accept_cnt;
    int   cyc = 0;

    fetch_queue_if #(.AW(32)) bus ();

    fetch_queue #(.DEPTH(4), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t rq[$];

    // Memory: accepts on req&&rdy, answers in order mem_lat cycles later.
    always @(posedge clk) begin
        rsp_t r;
        if (rst) begin
            rq.delete();
            accept_cnt = 0;
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
        end else begin
            if (bus.imem_req && bus.imem_rdy) begin
                r.addr = bus.imem_addr;
                r.due  = cyc + mem_lat - 1;
                rq.push_back(r);
                accept_cnt++;
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= rq[0].addr + 32'h1000;
                void'(rq.pop_front());
            end else begin
                bus.imem_rvalid <= 1'b0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int lat, input logic rdy, input logic core_rdy);
        mem_lat         = lat;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdy    = rdy;
        bus.ir_ready    = core_rdy;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    64'(bus.imem_req),  64'd0);
        chk({tag, "_addr"},   64'(bus.imem_addr), 64'd0);
        chk({tag, "_valid"},  64'(bus.ir_valid),  64'd0);
        chk({tag, "_ir"},     64'(bus.ir),        64'd0);
        chk({tag, "_ir_pc"},  64'(bus.ir_pc),     64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.imem_rdy    = 1'b0;
        bus.ir_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Streaming: 1-cycle memory, always-ready core.
        do_reset(1, 1'b1, 1'b1);
        chk_reset_vals("rst");
        step();
        chk("s_first_req",  64'(bus.imem_req),  64'd1);
        chk("s_first_addr", 64'(bus.imem_addr), 64'd0);
        step();
        chk("s_addr1",      64'(bus.imem_addr), 64'd1);
        chk("s_lat_valid",  64'(bus.ir_valid),  64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("s_valid%0d", i), 64'(bus.ir_valid),  64'd1);
            chk($sformatf("s_ir%0d", i),    64'(bus.ir),        64'(32'h1000 + i));
            chk($sformatf("s_pc%0d", i),    64'(bus.ir_pc),     64'(i));
            chk($sformatf("s_addr%0d", i),  64'(bus.imem_addr), 64'(i + 2));
        end

        // Backpressure: credit stops fetch at DEPTH, then drains in order.
        do_reset(1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step();
        chk("bp_accepts", 64'(accept_cnt), 64'd4);
        chk("bp_req_off", 64'(bus.imem_req), 64'd0);
        chk("bp_head_ir", 64'(bus.ir),       64'h1000);
        chk("bp_head_pc", 64'(bus.ir_pc),    64'd0);
        bus.ir_ready = 1'b1;
        step();
        chk("bp_req_on",  64'(bus.imem_req),  64'd1);
        chk("bp_addr4",   64'(bus.imem_addr), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) step();
            chk($sformatf("bp_ir%0d", i), 64'(bus.ir),    64'(32'h1000 + i));
            chk($sformatf("bp_pc%0d", i), 64'(bus.ir_pc), 64'(i));
        end

        // Redirect with three requests in flight, 3-cycle memory.
        do_reset(3, 1'b1, 1'b1);
        step();
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fl_req%0d", i),   64'(bus.imem_req), 64'd0);
            chk($sformatf("fl_valid%0d", i), 64'(bus.ir_valid), 64'd0);
            step();
        end
        chk("fl_req_on", 64'(bus.imem_req),  64'd1);
        chk("fl_addr40", 64'(bus.imem_addr), 64'h40);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fl_novalid%0d", i), 64'(bus.ir_valid), 64'd0);
            step();
        end
        chk("fl_first_valid", 64'(bus.ir_valid), 64'd1);
        chk("fl_first_pc",    64'(bus.ir_pc),    64'h40);
        chk("fl_first_ir",    64'(bus.ir),       64'h1040);

        // Redirects during FLUSH retarget fetch; last one wins.
        do_reset(3, 1'b1, 1'b1);
        step();
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h70;
        step();
        bus.redirect_pc = 32'h80;
        step();
        chk("rf_req_a", 64'(bus.imem_req), 64'd0);
        bus.redirect_pc = 32'h90;
        step();
        chk("rf_req_b", 64'(bus.imem_req), 64'd0);
        bus.redirect = 1'b0;
        step();
        chk("rf_req_on", 64'(bus.imem_req),  64'd1);
        chk("rf_addr90", 64'(bus.imem_addr), 64'h90);
        for (int i = 0; i < 4; i++) step();
        chk("rf_first_valid", 64'(bus.ir_valid), 64'd1);
        chk("rf_first_pc",    64'(bus.ir_pc),    64'h90);

        // Reset wins over a simultaneous redirect.
        do_reset(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step();
        rst             = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        chk_reset_vals("rr");
        rst          = 1'b0;
        bus.redirect = 1'b0;
        step();
        chk("rr_req",  64'(bus.imem_req),  64'd1);
        chk("rr_addr", 64'(bus.imem_addr), 64'd0);
        step();
        step();
        chk("rr_valid", 64'(bus.ir_valid), 64'd1);
        chk("rr_pc",    64'(bus.ir_pc),    64'd0);
        chk("rr_ir",    64'(bus.ir),       64'h1000);

        // Stalled memory: address holds; redirect with nothing outstanding
        // retargets the very next cycle.
        do_reset(1, 1'b0, 1'b1);
        step();
        chk("st_req",   64'(bus.imem_req),  64'd1);
        step();
        chk("st_hold",  64'(bus.imem_addr), 64'd0);
        chk("st_req2",  64'(bus.imem_req),  64'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h55;
        step();
        chk("st_rd_req",  64'(bus.imem_req),  64'd1);
        chk("st_rd_addr", 64'(bus.imem_addr), 64'h55);
        bus.redirect = 1'b0;
        bus.imem_rdy = 1'b1;
        step();
        step();
        chk("st_valid", 64'(bus.ir_valid), 64'd1);
        chk("st_pc",    64'(bus.ir_pc),    64'h55);
        chk("st_ir",    64'(bus.ir),       64'h1055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the single-cycle core. Generates word-granular fetch addresses, issues in-order requests to instruction memory, and buffers returned words in a small prefetch FIFO. Presents one instruction (`ir`) plus its address to the core through a valid/ready handshake. On a branch or jump redirect from the core, it flushes buffered and in-flight instructions and restarts fetch at the new target.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `AW`, 32: address width; addresses are word indices, so PC advances by 1.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out AW: word address of the request.
- `imem_rdy` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid; responses return in request order, at least one cycle after acceptance.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: core requests a fetch restart (taken branch or jump).
- `redirect_pc` in AW: restart address.
- `ir` out 32: instruction at FIFO head.
- `ir_pc` out AW: address of `ir`.
- `ir_valid` out 1: `ir` and `ir_pc` are valid.
- `ir_ready` in 1: core consumes `ir` this cycle.

## Operation
- State `fetch_pc` holds the next address to request. A request transfers when `imem_req && imem_rdy`. On transfer, `fetch_pc` increments by 1 modulo 2^AW, and `outstanding` increments.
- A tag FIFO or parallel PC FIFO records the address of each accepted request, so `ir_pc` matches the returned word.
- Credit rule: `imem_req` = 1 only in state RUN, and only when `count + outstanding < DEPTH`. Responses therefore never overflow the FIFO, and no data backpressure on memory is needed.
- On `imem_rvalid` in RUN, the word is pushed and `outstanding` decrements.
- Pop occurs when `ir_valid && ir_ready`. Push and pop in the same cycle leave `count` unchanged, and are legal when the FIFO is full.
- States:
  - RUN: normal operation.
  - FLUSH: stale responses are being dropped.
- Redirect, accepted in any state:
  - FIFO emptied, `ir_valid` forced to 0 next cycle, `fetch_pc` set to `redirect_pc`.
  - A request transferring in the redirect cycle is counted as stale.
  - A response arriving in the redirect cycle is discarded.
  - `drop_cnt` is loaded with the outstanding count after that cycle's transfer and response.
  - Next state is FLUSH if `drop_cnt` > 0, else RUN.
  - A pop in the redirect cycle is ignored.
- FLUSH:
  - No requests are issued.
  - Each `imem_rvalid` decrements `drop_cnt` and is discarded.
  - Transition to RUN in the cycle after `drop_cnt` reaches 0.
  - A redirect in FLUSH reloads `fetch_pc` only; `drop_cnt` keeps counting the remaining stale responses.
- `rst` overrides everything, including a simultaneous `redirect`. Reset mid-flight abandons outstanding requests; memory is reset by the same `rst`.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = 0, `ir_valid` = 0, `ir` = 0, `ir_pc` = 0.
  - `fetch_pc` = 0, `count` = 0, `outstanding` = 0, `drop_cnt` = 0, state RUN.
- First request is asserted in the first cycle after `rst` deasserts, with address 0.
- `imem_addr` is registered; it is stable while `imem_req` = 1 and `imem_rdy` = 0.
- Response to `ir_valid` latency:
  - 1 cycle (registered FIFO output) by default.
  - See Configuration for the bypass build.
- Throughput is one instruction per cycle when memory grants every cycle and the consumer is always ready.
- After a redirect with nothing outstanding, the first new request is issued the next cycle with `imem_addr = redirect_pc`.

## Configuration
- `FETCH_BYPASS_EN`
  - Defined: when the FIFO is empty and in RUN, `imem_rvalid` data and its PC drive `ir`/`ir_pc` combinationally with `ir_valid` = 1 in the same cycle.
    - If `ir_ready` is also 1, the word is consumed and not written to the FIFO.
    - Otherwise it is pushed as normal.
  - Undefined: all outputs come from FIFO registers, giving 1-cycle latency. No combinational path exists from memory inputs to `ir`/`ir_valid`.

## Test plan
- Reset, then `imem_rdy` = 1, 1-cycle memory returning `data = addr + 0x1000`, `ir_ready` = 1:
  - Addresses 0,1,2,3… are issued on consecutive cycles.
  - `ir` = 0x1000, 0x1001… with `ir_pc` 0,1,2…, one per cycle after the initial latency.
- `ir_ready` held 0 with DEPTH = 4: exactly 4 requests are accepted, then `imem_req` = 0.
  - `ir` stays at the addr-0 word.
  - Raising `ir_ready` drains 0..3 in order, and `imem_req` reasserts at address 4.
- 3-cycle memory latency, redirect to 0x40 while 3 requests are outstanding:
  - The 3 stale responses are dropped and no `ir_valid` occurs for them.
  - The next request is at 0x40 after the last stale response, and `ir_pc` = 0x40 is the first valid.
- Redirect to 0x80 during FLUSH, then redirect to 0x90 before drain completes: the first fetched address is 0x90.
- `rst` asserted together with `redirect` (target 0x20) mid-stream:
  - All outputs take their reset values.
  - Fetch restarts at address 0.
- Bypass build, empty FIFO: `imem_rvalid` with `ir_ready` = 1 gives `ir_valid` = 1 in the same cycle, and `count` stays 0.
